// File: rtl/writeread.sv
// Serial RRAM access controller: forming pulse, LSB-first serial write from the
// register word, and serial read into a 32-entry cache addressed by cache_add.
module writeread #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  CE,
    input  logic [DATA_WIDTH-1:0] data_register,
    output logic [DATA_WIDTH-1:0] data_cache,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] cache_add,
    input  logic                  forming,
    output logic                  rram_re,
    output logic                  rram_we,
    inout  logic                  rram_data,
    output logic                  rram_ce
);

    localparam int CW    = $clog2(DATA_WIDTH);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FORM  = 3'd1;
    localparam logic [2:0] WRITE = 3'd2;
    localparam logic [2:0] READ  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]            state;
    logic [CW-1:0]         count;
    logic [CW-1:0]         count_inc;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic                  drive_en;
    logic                  drive_bit;
    logic [DATA_WIDTH-1:0] cache [DEPTH];

    assign count_inc  = count + CW'(1);
    assign data_cache = cache[cache_add];
    assign rram_data  = drive_en ? drive_bit : 1'bz;

    // shift_reg holds the latched write word in WRITE and assembles the word in READ
    always_ff @(posedge clk or posedge CE) begin
        if (CE) begin
            state     <= IDLE;
            count     <= '0;
            shift_reg <= '0;
            addr_reg  <= '0;
            rram_ce   <= 1'b0;
            rram_we   <= 1'b0;
            rram_re   <= 1'b0;
            drive_en  <= 1'b0;
            drive_bit <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                cache[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (forming) begin
                        state     <= FORM;
                        rram_ce   <= 1'b1;
                        rram_we   <= 1'b1;
                        drive_en  <= 1'b1;
                        drive_bit <= 1'b1;
                    end else if (we) begin
                        state     <= WRITE;
                        shift_reg <= data_register;
                        addr_reg  <= cache_add;
                        rram_ce   <= 1'b1;
                        rram_we   <= 1'b1;
                        drive_en  <= 1'b1;
                        drive_bit <= data_register[0];
                    end else if (re) begin
                        state    <= READ;
                        addr_reg <= cache_add;
                        rram_ce  <= 1'b1;
                        rram_re  <= 1'b1;
                    end
                end
                FORM: begin
                    if (count == LAST) begin
                        state    <= DONE;
                        rram_ce  <= 1'b0;
                        rram_we  <= 1'b0;
                        drive_en <= 1'b0;
                    end else begin
                        count <= count_inc;
                    end
                end
                WRITE: begin
                    if (count == LAST) begin
                        state           <= DONE;
                        cache[addr_reg] <= shift_reg;
                        rram_ce         <= 1'b0;
                        rram_we         <= 1'b0;
                        drive_en        <= 1'b0;
                    end else begin
                        count     <= count_inc;
                        drive_bit <= shift_reg[count_inc];
                    end
                end
                READ: begin
                    shift_reg[count] <= rram_data;
                    if (count == LAST) begin
                        state           <= DONE;
                        cache[addr_reg] <= {rram_data, shift_reg[DATA_WIDTH-2:0]};
                        rram_ce         <= 1'b0;
                        rram_re         <= 1'b0;
                    end else begin
                        count <= count_inc;
                    end
                end
                DONE: begin
                    if (!forming && !we && !re) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeread.sv
// Randomized self-checking bench for writeread against a cache-array reference
// model; per-cycle strobe/pin expectations derive from the operation rules.
module tb_writeread;

    logic        clk = 1'b0;
    logic        CE;
    logic        re, we, forming;
    logic [31:0] data_register;
    logic [31:0] data_cache;
    logic [4:0]  cache_add;
    logic        rram_re, rram_we, rram_ce;
    wire         rram_data;
    logic        tb_en, tb_bit;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [31:0] model_cache [32];

    assign rram_data = tb_en ? tb_bit : 1'bz;

    writeread #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .CE           (CE),
        .data_register(data_register),
        .data_cache   (data_cache),
        .re           (re),
        .we           (we),
        .cache_add    (cache_add),
        .forming      (forming),
        .rram_re      (rram_re),
        .rram_we      (rram_we),
        .rram_data    (rram_data),
        .rram_ce      (rram_ce)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_strobes(input string tag, input logic ce, input logic wr, input logic rd);
        check(tag, {29'b0, rram_ce, rram_we, rram_re}, {29'b0, ce, wr, rd});
    endtask

    task automatic check_pin(input string tag, input logic exp);
        check(tag, {31'b0, rram_data}, {31'b0, exp});
    endtask

    task automatic check_cache(input string tag);
        for (int a = 0; a < 32; a++) begin
            cache_add = 5'(a);
            #1;
            check(tag, data_cache, model_cache[a]);
        end
    endtask

    // 0 = forming, 1 = write, 2 = read
    function automatic int op_of(input logic [2:0] req);
        if (req[2]) return 0;
        if (req[1]) return 1;
        return 2;
    endfunction

    task automatic run_op(input logic [2:0] req, input logic [31:0] word,
                          input logic [4:0] addr, input int unsigned hold);
        int kind;
        kind = op_of(req);
        forming       = req[2];
        we            = req[1];
        re            = req[0];
        data_register = word;
        cache_add     = addr;
        tb_en         = (kind == 2);
        tb_bit        = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_strobes("op_strobes", 1'b1, kind != 2, kind == 2);
            if (kind == 2) begin
                tb_bit = word[i];
                #1;
                check_pin("read_pin_released", word[i]);
            end else begin
                #1;
                check_pin(kind == 0 ? "form_pin" : "write_pin", kind == 0 ? 1'b1 : word[i]);
            end
            forming       = 1'($urandom);
            we            = 1'($urandom);
            re            = 1'($urandom);
            data_register = $urandom;
            cache_add     = 5'($urandom);
            #1;
            check("live_cache", data_cache, model_cache[cache_add]);
        end
        @(negedge clk);
        if (kind != 0) model_cache[addr] = word;
        tb_en   = 1'b1;
        tb_bit  = 1'b0;
        forming = req[2];
        we      = req[1];
        re      = req[0];
        check_strobes("done_strobes", 1'b0, 1'b0, 1'b0);
        #1;
        check_pin("done_pin", 1'b0);
        repeat (hold) begin
            @(negedge clk);
            check_strobes("held_no_repeat", 1'b0, 1'b0, 1'b0);
        end
        forming = 1'b0;
        we      = 1'b0;
        re      = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_strobes("idle_strobes", 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] w;
        logic [4:0]  a;
        CE            = 1'b1;
        re            = 1'b0;
        we            = 1'b0;
        forming       = 1'b0;
        data_register = '0;
        cache_add     = '0;
        tb_en         = 1'b1;
        tb_bit        = 1'b0;
        for (int i = 0; i < 32; i++) model_cache[i] = '0;

        #2;
        check_strobes("reset_strobes", 1'b0, 1'b0, 1'b0);
        check_pin("reset_pin", 1'b0);
        check_cache("reset_cache");
        @(negedge clk);
        CE = 1'b0;
        @(negedge clk);
        check_strobes("post_reset_strobes", 1'b0, 1'b0, 1'b0);

        run_op(3'b100, 32'hFFFF_0000, 5'd3, 3);
        check_cache("form_cache");
        run_op(3'b010, 32'h0000_5A93, 5'd0, 2);
        check_cache("write_cache");
        run_op(3'b001, 32'hA5A5_0F0F, 5'd7, 1);
        check_cache("read_cache");
        run_op(3'b111, 32'h1234_5678, 5'd9, 4);
        check_cache("priority_cache");

        // abort a write during its 11th cycle
        w             = $urandom | 32'h1;
        a             = 5'd12;
        data_register = w;
        cache_add     = a;
        we            = 1'b1;
        tb_en         = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_strobes("abort_pre_strobes", 1'b1, 1'b1, 1'b0);
            #1;
            check_pin("abort_pre_pin", w[i]);
        end
        @(negedge clk);
        CE = 1'b1;
        we = 1'b0;
        #1;
        check_strobes("abort_strobes", 1'b0, 1'b0, 1'b0);
        tb_en  = 1'b1;
        tb_bit = 1'b0;
        #1;
        check_pin("abort_pin", 1'b0);
        for (int i = 0; i < 32; i++) model_cache[i] = '0;
        cache_add = a;
        #1;
        check("abort_entry", data_cache, 32'h0);
        cache_add = 5'd0;
        #1;
        check("abort_cleared", data_cache, 32'h0);
        CE = 1'b0;
        @(negedge clk);
        run_op(3'b010, ~w, a, 0);
        check_cache("after_abort_cache");

        for (int n = 0; n < 24; n++) begin
            run_op(3'($urandom_range(1, 7)), $urandom, 5'($urandom), $urandom_range(0, 3));
            check_cache("random_cache");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
